// File: rtl/load_store_unit.sv
// Load/store unit: turns an ALU effective address plus rs2 into one valid/ack
// data-bus transaction, stalls the core while it is in flight, and returns
// lane-selected, sign/zero-extended load data. Misaligned, illegal-size and
// timed-out accesses end in a one-cycle fault pulse instead of done.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  // Last BUSY cycle index that may still see an ack (timer counts from 0).
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic        req_s;
  logic        illegal_s;
  logic        timeout_s;
  logic        is_load_r;
  logic [2:0]  funct3_r;
  logic [1:0]  offset_r;
  logic [15:0] timer_r;

  // Byte enables: byte/half shifted to the addressed lane, word uses all four.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the slave can pick any enabled byte.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign/zero-extend by size.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] d);
    logic [31:0] lane;
    lane = d >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_extend = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_extend = {24'h000000, lane[7:0]};
      3'b101:  load_extend = {16'h0000, lane[15:0]};
      default: load_extend = lane;
    endcase
  endfunction

  assign req_s     = mem_read | mem_write;
  assign timeout_s = (timer_r == TIMEOUT_LAST);
  assign stall     = ((state_r == S_IDLE) & req_s) | (state_r == S_BUSY);

  // Legality of the request presented in IDLE: op conflict, size code, alignment.
  always_comb begin
    illegal_s = 1'b0;
    if (mem_read && mem_write) begin
      illegal_s = 1'b1;
    end else if (mem_read) begin
      case (funct3)
        3'b000, 3'b100: illegal_s = 1'b0;
        3'b001, 3'b101: illegal_s = addr[0];
        3'b010:         illegal_s = (addr[1:0] != 2'b00);
        default:        illegal_s = 1'b1;
      endcase
    end else if (mem_write) begin
      case (funct3)
        3'b000:  illegal_s = 1'b0;
        3'b001:  illegal_s = addr[0];
        3'b010:  illegal_s = (addr[1:0] != 2'b00);
        default: illegal_s = 1'b1;
      endcase
    end else begin
      illegal_s = 1'b0;
    end
  end

  // Next-state decode; bus_ack only matters while BUSY.
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          state_nxt_s = illegal_s ? S_FAULT : S_BUSY;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (bus_ack) begin
          state_nxt_s = S_DONE;
        end else if (timeout_s) begin
          state_nxt_s = S_FAULT;
        end else begin
          state_nxt_s = S_BUSY;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      S_FAULT: state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, bus outputs, timer, result pulses and load data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0000_0000;
      bus_wdata <= 32'h0000_0000;
      bus_be    <= 4'b0000;
      rdata     <= 32'h0000_0000;
      done      <= 1'b0;
      fault     <= 1'b0;
      timer_r   <= 16'h0000;
      is_load_r <= 1'b0;
      funct3_r  <= 3'b000;
      offset_r  <= 2'b00;
    end else begin
      state_r <= state_nxt_s;
      done    <= (state_nxt_s == S_DONE);
      fault   <= (state_nxt_s == S_FAULT);
      case (state_r)
        S_IDLE: begin
          if (req_s && !illegal_s) begin
            is_load_r <= mem_read;
            funct3_r  <= funct3;
            offset_r  <= addr[1:0];
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= byte_en(funct3, addr[1:0]);
            bus_wdata <= mem_write ? store_data(funct3, wdata) : 32'h0000_0000;
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            timer_r <= 16'h0000;
            if (is_load_r) begin
              rdata <= load_extend(funct3_r, offset_r, bus_rdata);
            end
          end else if (timeout_s) begin
            bus_req <= 1'b0;
            timer_r <= 16'h0000;
          end else begin
            timer_r <= timer_r + 16'h0001;
          end
        end
        default: begin
          timer_r <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a small bus slave and a
// scoreboard queue of expected access outcomes (TIMEOUT=4 instance).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_vec = 0;
  int n_err = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .done(done), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brd;       // slave read data
    int          ack_at;    // BUSY cycle (1-based) that gets the ack, 0 = never
    logic        exp_fault;
    logic [31:0] exp_rdata;
    int          exp_stall;
    int          exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[16];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one access from an IDLE negedge and follow it to its done/fault pulse.
  task automatic do_access(input vec_t v);
    vec_t e;
    int   stall_n = 0;
    int   req_n = 0;
    bit   fin = 0;
    mem_read  = v.rd;
    mem_write = v.wr;
    funct3    = v.f3;
    addr      = v.addr;
    wdata     = v.wdata;
    sb_q.push_back(v);
    for (int c = 0; c < 40 && !fin; c++) begin
      #1;
      if (stall) stall_n++;
      if (bus_req) begin
        req_n++;
        if (req_n == 1) begin
          chk({v.name, " bus_addr"}, bus_addr, {sb_q[0].addr[31:2], 2'b00});
          chk({v.name, " bus_be"}, {28'h0, bus_be}, {28'h0, sb_q[0].exp_be});
          chk({v.name, " bus_we"}, {31'h0, bus_we}, {31'h0, sb_q[0].wr});
          if (sb_q[0].wr) chk({v.name, " bus_wdata"}, bus_wdata, sb_q[0].exp_wdata);
        end
        bus_ack   = (req_n == v.ack_at);
        bus_rdata = v.brd;
      end else begin
        bus_ack = 1'b0;
      end
      if (done || fault) begin
        e = sb_q.pop_front();
        chk({e.name, " fault"}, {31'h0, fault}, {31'h0, e.exp_fault});
        chk({e.name, " done"}, {31'h0, done}, {31'h0, !e.exp_fault});
        chk({e.name, " rdata"}, rdata, e.exp_rdata);
        chk({e.name, " stall_cycles"}, 32'(stall_n), 32'(e.exp_stall));
        chk({e.name, " req_cycles"}, 32'(req_n), 32'(e.exp_req));
        fin = 1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      @(negedge clk);
    end
    if (!fin) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no done/fault within 40 cycles", v.name);
      void'(sb_q.pop_front());
      mem_read  = 1'b0;
      mem_write = 1'b0;
      bus_ack   = 1'b0;
    end
    #1;
    chk({v.name, " pulse_end"}, {30'h0, done, fault}, 32'h0);
    chk({v.name, " idle_stall"}, {31'h0, stall}, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    //           name     rd    wr    f3      addr          wdata         brd           ack flt   rdata         stl req be       wdata
    vecs[0]  = '{"LW",    1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,       32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 4, 3, 4'b1111, 32'h0};
    vecs[1]  = '{"LB",    1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,       32'h80112233, 1, 1'b0, 32'hFFFFFF80, 2, 1, 4'b1000, 32'h0};
    vecs[2]  = '{"LBU",   1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,       32'h80112233, 1, 1'b0, 32'h00000080, 2, 1, 4'b1000, 32'h0};
    vecs[3]  = '{"LHU",   1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,       32'hABCD0000, 1, 1'b0, 32'h0000ABCD, 2, 1, 4'b1100, 32'h0};
    vecs[4]  = '{"SB",    1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h000000A5, 32'h0,       1, 1'b0, 32'h0000ABCD, 2, 1, 4'b0010, 32'hA5A5A5A5};
    vecs[5]  = '{"SHmis", 1'b0, 1'b1, 3'b001, 32'h0000_0301, 32'h0000BEEF, 32'h0,       1, 1'b1, 32'h0000ABCD, 1, 0, 4'b0000, 32'h0};
    vecs[6]  = '{"LWto",  1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,       32'h12345678, 0, 1'b1, 32'h0000ABCD, 5, 4, 4'b1111, 32'h0};
    vecs[7]  = '{"LH",    1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,       32'h80010000, 1, 1'b0, 32'hFFFF8001, 2, 1, 4'b1100, 32'h0};
    vecs[8]  = '{"LB1",   1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,       32'h00007F00, 2, 1'b0, 32'h0000007F, 3, 2, 4'b0010, 32'h0};
    vecs[9]  = '{"SW",    1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h12345678, 32'h0,       2, 1'b0, 32'h0000007F, 3, 2, 4'b1111, 32'h12345678};
    vecs[10] = '{"SH",    1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hBEEF1234, 32'h0,       1, 1'b0, 32'h0000007F, 2, 1, 4'b1100, 32'h12341234};
    vecs[11] = '{"RW",    1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0,       32'h0,        1, 1'b1, 32'h0000007F, 1, 0, 4'b0000, 32'h0};
    vecs[12] = '{"SBU",   1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,       32'h0,        1, 1'b1, 32'h0000007F, 1, 0, 4'b0000, 32'h0};
    vecs[13] = '{"LWmis", 1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,       32'h0,        1, 1'b1, 32'h0000007F, 1, 0, 4'b0000, 32'h0};
    vecs[14] = '{"L011",  1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,       32'h0,        1, 1'b1, 32'h0000007F, 1, 0, 4'b0000, 32'h0};
    vecs[15] = '{"LHU0",  1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,       32'h1234FFFF, 1, 1'b0, 32'h0000FFFF, 2, 1, 4'b0011, 32'h0};

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset bus_req", {31'h0, bus_req}, 32'h0);
    chk("reset pulses", {30'h0, done, fault}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset bus_addr", bus_addr, 32'h0);
    chk("reset be_we", {27'h0, bus_we, bus_be}, 32'h0);
    chk("reset stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) do_access(vecs[i]);

    // Ack while idle must not complete anything.
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("idle_ack done", {30'h0, done, fault}, 32'h0);
    chk("idle_ack bus_req", {31'h0, bus_req}, 32'h0);
    chk("idle_ack rdata", rdata, 32'h0000FFFF);
    @(negedge clk);

    // Reset in BUSY with an ack in the same cycle: ack discarded, rdata cleared.
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0400;
    begin
      bit got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        #1;
        if (bus_req) got = 1;
      end
      chk("rstbusy reached_busy", {31'h0, got}, 32'h1);
    end
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h55555555; mem_read = 1'b0;
    @(negedge clk);
    #1;
    chk("rstbusy bus_req", {31'h0, bus_req}, 32'h0);
    chk("rstbusy done", {30'h0, done, fault}, 32'h0);
    chk("rstbusy rdata", rdata, 32'h0);
    chk("rstbusy stall", {31'h0, stall}, 32'h0);
    rst = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("rstbusy after done", {30'h0, done, fault}, 32'h0);
    chk("rstbusy after rdata", rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
